// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types for the data-memory port arbiter: store widths,
//            arbiter FSM states and read-data ownership tags.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Store width encoding understood by mem_stage
  typedef enum logic [1:0] {
    ST_BYTE = 2'b00,
    ST_HALF = 2'b01,
    ST_WORD = 2'b10
  } st_type_e;

  // Arbiter states: normal core priority, or one forced loader slot
  typedef enum logic [0:0] {
    S_CORE_PRI  = 1'b0,
    S_LDR_FORCE = 1'b1
  } arb_state_e;

  // Who owns the read data returning next cycle
  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    LDR  = 2'd2
  } rd_owner_e;

  // Starvation counter width; covers STARVE_MAX up to 15
  localparam int CNT_W = 4;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module   : starve_counter
// Brief    : Saturating wait counter for the loader. 'hit' is asserted in the
//            cycle the count is about to reach (or sits at) STARVE_MAX while
//            the loader is still waiting.
// Revision : 1.0 - initial release
// ============================================================================
module starve_counter
  import lsu_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic             hit,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] MAX_M1_C = CNT_W'(STARVE_MAX - 1);

  // A waiting cycle that lands on the limit triggers the forced slot
  assign hit = inc && !clr && (cnt >= MAX_M1_C);

  // Count waiting cycles; clear wins, saturate at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : starve_counter
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares the mem_stage data port between the MEM-stage access and
//            an external loader/debug port. Core has priority; a starvation
//            counter forces a loader slot after STARVE_MAX waiting cycles.
//            Read data returns one cycle after the grant, tagged by owner.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import lsu_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_core_req,
  input  logic        i_core_wren,
  input  logic [1:0]  i_core_st_type,
  input  logic [31:0] i_core_addr,
  input  logic [31:0] i_core_wdata,
  output logic        o_core_stall,
  output logic        o_core_rvalid,
  output logic [31:0] o_core_rdata,
  input  logic        i_ldr_req,
  input  logic        i_ldr_wren,
  input  logic [31:0] i_ldr_addr,
  input  logic [31:0] i_ldr_wdata,
  output logic        o_ldr_gnt,
  output logic        o_ldr_rvalid,
  output logic [31:0] o_ldr_rdata,
  output logic        o_mem_wren,
  output logic [1:0]  o_mem_st_type,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  arb_state_e       state;
  arb_state_e       next_state;
  rd_owner_e        rd_owner;
  rd_owner_e        rd_owner_next;
  logic             core_grant;
  logic             ldr_grant;
  logic             starve_inc;
  logic             starve_clr;
  logic             starve_hit;
  logic [CNT_W-1:0] starve_cnt;

  // Loader waits whenever it asks and is not served; any idle or grant clears
  assign starve_inc = i_ldr_req && !ldr_grant;
  assign starve_clr = ldr_grant || !i_ldr_req;

  starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_counter (
    .clk (i_clk),
    .rst (i_rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .hit (starve_hit),
    .cnt (starve_cnt)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_CORE_PRI;
    end else begin
      state <= next_state;
    end
  end

  // Grant decision and next state; forced slot lasts exactly one cycle
  always_comb begin
    core_grant = 1'b0;
    ldr_grant  = 1'b0;
    next_state = state;
    case (state)
      S_CORE_PRI: begin
        if (i_core_req) begin
          core_grant = 1'b1;
        end else if (i_ldr_req) begin
          ldr_grant = 1'b1;
        end
        next_state = starve_hit ? S_LDR_FORCE : S_CORE_PRI;
      end
      S_LDR_FORCE: begin
        // A loader that dropped its request gives the slot back to the core
        if (i_ldr_req) begin
          ldr_grant = 1'b1;
        end else if (i_core_req) begin
          core_grant = 1'b1;
        end
        next_state = S_CORE_PRI;
      end
      default: begin
        next_state = S_CORE_PRI;
      end
    endcase
  end

  // Memory-side mux; idle cycles present an all-zero, non-writing access
  always_comb begin
    o_mem_wren    = 1'b0;
    o_mem_st_type = ST_BYTE;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    rd_owner_next = NONE;
    if (core_grant) begin
      o_mem_wren    = i_core_wren;
      o_mem_st_type = i_core_st_type;
      o_mem_addr    = i_core_addr;
      o_mem_wdata   = i_core_wdata;
      rd_owner_next = i_core_wren ? NONE : CORE;
    end else if (ldr_grant) begin
      o_mem_wren    = i_ldr_wren;
      o_mem_st_type = ST_WORD;
      o_mem_addr    = i_ldr_addr;
      o_mem_wdata   = i_ldr_wdata;
      rd_owner_next = i_ldr_wren ? NONE : LDR;
    end
  end

  // Read ownership tag for data returning next cycle; reset drops it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_owner <= NONE;
    end else begin
      rd_owner <= rd_owner_next;
    end
  end

  assign o_core_stall  = i_core_req && !core_grant;
  assign o_ldr_gnt     = ldr_grant;
  assign o_core_rvalid = (rd_owner == CORE);
  assign o_ldr_rvalid  = (rd_owner == LDR);
  assign o_core_rdata  = o_core_rvalid ? i_mem_rdata : 32'h0;
  assign o_ldr_rdata   = o_ldr_rvalid  ? i_mem_rdata : 32'h0;

endmodule : dmem_arbiter
`default_nettype wire
